jtbubl_rom_server: RTL and testbench

JTBUBL_ROM_SERVER -- requirements
Module: jtbubl_rom_server

---
 rtl/jtbubl_rom_pkg.sv | 17 +
 rtl/jtbubl_rom_cache.sv | 64 ++++++
 rtl/jtbubl_rom_server.sv | 148 ++++++++++++++
 tb/tb_jtbubl_rom_server.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_rom_pkg.sv
// Shared definitions for the Bubble Bobble ROM server.
// Contents:
//   state_t          - fetch FSM state encoding
//   MAIN_OFFSET_DEF  - default SDRAM word address of the main CPU ROM region
//   SUB_OFFSET_DEF   - default SDRAM word address of the sub CPU ROM region
package jtbubl_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

    localparam logic [21:0] MAIN_OFFSET_DEF = 22'h00_0000;
    localparam logic [21:0] SUB_OFFSET_DEF  = 22'h01_0000;

endpackage

// File: rtl/jtbubl_rom_cache.sv
// One-word read cache for a single byte-addressed ROM client.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   clr                 - ROM download in progress: invalidate, suppress misses
//   cs, addr            - client request (byte address)
//   pending             - a fetch for this client is in flight
//   wr_en/wr_valid      - load wr_tag/wr_data; wr_valid is the new valid bit
//   ok, data            - hit indication and selected byte
//   miss                - client needs a fetch
module jtbubl_rom_cache #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          pending,
    input  logic          wr_en,
    input  logic          wr_valid,
    input  logic [AW-2:0] wr_tag,
    input  logic [15:0]   wr_data,
    output logic          ok,
    output logic [7:0]    data,
    output logic          miss
);

    logic [AW-2:0] tag_q,   tag_d;
    logic          valid_q, valid_d;
    logic [15:0]   word_q,  word_d;

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        word_d  = word_q;
        if (wr_en) begin
            tag_d   = wr_tag;
            word_d  = wr_data;
            valid_d = wr_valid;
        end
        // A download rewrites the ROM contents, so nothing cached survives it
        if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    // ok depends only on registered cache state plus the live request
    assign ok   = cs && valid_q && (tag_q == addr[AW-1:1]) && !pending;
    assign data = addr[0] ? word_q[15:8] : word_q[7:0];
    assign miss = cs && !ok && !clr;

endmodule

// File: rtl/jtbubl_rom_server.sv
// Serves the main and sub CPU ROMs from a shared SDRAM port.
// Each client has a one-word cache; misses are fetched one at a time,
// with round-robin arbitration when both clients miss together.
// Ports:
//   clk24, rst_n                  - clock, asynchronous active-low reset
//   downloading                   - ROM download in progress
//   main_rom_* / sub_rom_*        - client byte-addressed read ports
//   sdram_req/addr/ack/rdy/data   - SDRAM word read port
module jtbubl_rom_server
    import jtbubl_rom_pkg::*;
#(
    parameter logic [21:0] SUB_OFFSET  = SUB_OFFSET_DEF,
    parameter logic [21:0] MAIN_OFFSET = MAIN_OFFSET_DEF
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        main_rom_cs,
    input  logic [17:0] main_rom_addr,
    output logic        main_rom_ok,
    output logic [7:0]  main_rom_data,
    input  logic        sub_rom_cs,
    input  logic [14:0] sub_rom_addr,
    output logic        sub_rom_ok,
    output logic [7:0]  sub_rom_data,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_data
);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;   // 0 = main, 1 = sub
    logic        last_q,  last_d;    // client granted most recently
    logic        req_q,   req_d;
    logic [21:0] addr_q,  addr_d;
    logic [16:0] tag_q,   tag_d;     // word address of the fetch in flight

    logic main_miss, sub_miss;
    logic fetch_done;
    logic pick;

    // Completion also covers ack and rdy arriving together
    assign fetch_done = ((state_q == ST_WAIT_ACK) && sdram_ack && sdram_rdy) ||
                        ((state_q == ST_WAIT_RDY) && sdram_rdy);

    // Contention goes to the client not served last
    assign pick = (main_miss && sub_miss) ? !last_q : sub_miss;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        req_d   = req_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if ((main_miss || sub_miss) && !downloading) begin
                    grant_d = pick;
                    last_d  = pick;
                    req_d   = 1'b1;
                    state_d = ST_WAIT_ACK;
                    if (pick) begin
                        tag_d  = {3'b000, sub_rom_addr[14:1]};
                        addr_d = SUB_OFFSET + {8'd0, sub_rom_addr[14:1]};
                    end else begin
                        tag_d  = main_rom_addr[17:1];
                        addr_d = MAIN_OFFSET + {5'd0, main_rom_addr[17:1]};
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = sdram_rdy ? ST_IDLE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (sdram_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;   // so that main wins the first contention
            req_q   <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    logic busy;
    assign busy = (state_q != ST_IDLE);

    jtbubl_rom_cache #(.AW(18)) u_main_cache (
        .clk      (clk24),
        .rst_n    (rst_n),
        .clr      (downloading),
        .cs       (main_rom_cs),
        .addr     (main_rom_addr),
        .pending  (busy && !grant_q),
        .wr_en    (fetch_done && !grant_q),
        .wr_valid (!downloading),
        .wr_tag   (tag_q),
        .wr_data  (sdram_data),
        .ok       (main_rom_ok),
        .data     (main_rom_data),
        .miss     (main_miss)
    );

    jtbubl_rom_cache #(.AW(15)) u_sub_cache (
        .clk      (clk24),
        .rst_n    (rst_n),
        .clr      (downloading),
        .cs       (sub_rom_cs),
        .addr     (sub_rom_addr),
        .pending  (busy && grant_q),
        .wr_en    (fetch_done && grant_q),
        .wr_valid (!downloading),
        .wr_tag   (tag_q[13:0]),
        .wr_data  (sdram_data),
        .ok       (sub_rom_ok),
        .data     (sub_rom_data),
        .miss     (sub_miss)
    );

endmodule

// File: tb/tb_jtbubl_rom_server.sv
// Directed bench for jtbubl_rom_server with hand-computed expectations.
module tb_jtbubl_rom_server;

    logic        clk24 = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        main_rom_cs;
    logic [17:0] main_rom_addr;
    logic        main_rom_ok;
    logic [7:0]  main_rom_data;
    logic        sub_rom_cs;
    logic [14:0] sub_rom_addr;
    logic        sub_rom_ok;
    logic [7:0]  sub_rom_data;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk24 = ~clk24;

    jtbubl_rom_server #(
        .SUB_OFFSET  (22'h01_0000),
        .MAIN_OFFSET (22'h00_0000)
    ) dut (
        .clk24         (clk24),
        .rst_n         (rst_n),
        .downloading   (downloading),
        .main_rom_cs   (main_rom_cs),
        .main_rom_addr (main_rom_addr),
        .main_rom_ok   (main_rom_ok),
        .main_rom_data (main_rom_data),
        .sub_rom_cs    (sub_rom_cs),
        .sub_rom_addr  (sub_rom_addr),
        .sub_rom_ok    (sub_rom_ok),
        .sub_rom_data  (sub_rom_data),
        .sdram_req     (sdram_req),
        .sdram_addr    (sdram_addr),
        .sdram_ack     (sdram_ack),
        .sdram_rdy     (sdram_rdy),
        .sdram_data    (sdram_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk24);
        #1;
    endtask

    // Ack in one cycle, data in the next
    task automatic resp(input logic [15:0] d);
        sdram_ack = 1'b1;
        step();
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b1;
        sdram_data = d;
        step();
        sdram_rdy = 1'b0;
    endtask

    // Ack and data together
    task automatic ack_rdy(input logic [15:0] d);
        sdram_ack  = 1'b1;
        sdram_rdy  = 1'b1;
        sdram_data = d;
        step();
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        downloading = 1'b0;
        main_rom_cs = 1'b0; main_rom_addr = '0;
        sub_rom_cs = 1'b0;  sub_rom_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = '0;

        // Reset state
        #2;
        chk("rst main_ok",   main_rom_ok,   0);
        chk("rst sub_ok",    sub_rom_ok,    0);
        chk("rst main_data", main_rom_data, 0);
        chk("rst sub_data",  sub_rom_data,  0);
        chk("rst req",       sdram_req,     0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Main miss
        main_rom_cs = 1'b1; main_rom_addr = 18'h00101;
        step();
        chk("miss req",       sdram_req,  1);
        chk("miss addr",      sdram_addr, 22'h000080);
        chk("miss ok pend",   main_rom_ok, 0);
        step();
        chk("wait_ack req",   sdram_req,  1);
        chk("wait_ack addr",  sdram_addr, 22'h000080);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk("ack clears req", sdram_req, 0);
        sdram_rdy = 1'b1; sdram_data = 16'hA55A;
        #1;
        chk("rdy cycle ok",   main_rom_ok, 0);
        step();
        sdram_rdy = 1'b0;
        chk("fill ok",        main_rom_ok,   1);
        chk("fill data",      main_rom_data, 8'hA5);

        // Hit on the other byte of the same word
        main_rom_addr = 18'h00100;
        #1;
        chk("hit ok",   main_rom_ok,   1);
        chk("hit data", main_rom_data, 8'h5A);
        step();
        chk("hit no req", sdram_req, 0);

        // Contention right after reset: main, then sub
        main_rom_cs = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        main_rom_cs = 1'b1; main_rom_addr = 18'h00200;
        sub_rom_cs  = 1'b1; sub_rom_addr  = 15'h0004;
        step();
        chk("cont1 req",  sdram_req,  1);
        chk("cont1 main", sdram_addr, 22'h000100);
        ack_rdy(16'h1111);
        chk("cont1 main ok", main_rom_ok, 1);
        chk("cont1 req low", sdram_req,   0);
        step();
        chk("cont1 sub",  sdram_addr, 22'h010002);
        chk("cont1 sub req", sdram_req, 1);
        chk("main hit during sub fetch", main_rom_ok, 1);
        ack_rdy(16'h2222);
        chk("cont1 sub ok",   sub_rom_ok,   1);
        chk("cont1 sub data", sub_rom_data, 8'h22);

        // Main-only fetch makes main the last grant, so sub wins next contention
        sub_rom_cs = 1'b0; main_rom_addr = 18'h00400;
        step();
        chk("solo main addr", sdram_addr, 22'h000200);
        ack_rdy(16'h3333);
        main_rom_addr = 18'h00500;
        sub_rom_cs = 1'b1; sub_rom_addr = 15'h0020;
        step();
        chk("cont2 sub first", sdram_addr, 22'h010010);
        ack_rdy(16'h4444);
        step();
        chk("cont2 main next", sdram_addr, 22'h000280);
        ack_rdy(16'h5555);
        chk("cont2 main data", main_rom_data, 8'h55);

        // cs dropped mid-fetch
        sub_rom_cs = 1'b0; main_rom_addr = 18'h00600;
        step();
        chk("drop req addr", sdram_addr, 22'h000300);
        main_rom_cs = 1'b0;
        step();
        resp(16'hBEEF);
        main_rom_cs = 1'b1;
        #1;
        chk("drop reassert ok",   main_rom_ok,   1);
        chk("drop reassert data", main_rom_data, 8'hEF);
        step();
        chk("drop no refetch", sdram_req, 0);

        // Download pulse
        sub_rom_cs = 1'b1; sub_rom_addr = 15'h0020;
        #1;
        chk("pre dl sub ok", sub_rom_ok, 1);
        downloading = 1'b1;
        step();
        chk("dl main ok", main_rom_ok, 0);
        chk("dl sub ok",  sub_rom_ok,  0);
        chk("dl no req",  sdram_req,   0);
        downloading = 1'b0;
        step();
        chk("post dl req",     sdram_req,  1);
        chk("post dl sub addr", sdram_addr, 22'h010010);
        ack_rdy(16'h4444);
        step();
        chk("post dl main addr", sdram_addr, 22'h000300);
        ack_rdy(16'hBEEF);
        chk("post dl main ok", main_rom_ok, 1);

        // Reset while waiting for data
        sub_rom_cs = 1'b0; main_rom_addr = 18'h00700;
        step();
        chk("rr req", sdram_addr, 22'h000380);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rr req low",  sdram_req,   0);
        chk("rr addr clr", sdram_addr,  0);
        chk("rr data clr", main_rom_data, 0);
        main_rom_cs = 1'b0;
        step();
        rst_n = 1'b1;
        sdram_rdy = 1'b1; sdram_data = 16'h1234;
        step();
        sdram_rdy = 1'b0;
        main_rom_cs = 1'b1;
        #1;
        chk("stray rdy no write", main_rom_ok, 0);
        step();
        chk("refetch req",  sdram_req,  1);
        chk("refetch addr", sdram_addr, 22'h000380);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
